oam_dma_ctrl: RTL and testbench
===============================

# oam_dma_ctrl

Sprite-DMA sequencer and bus arbiter between the 6502 core and the shared CPU memory bus. A CPU write to the DMA trigger register starts a transfer. The block then stalls the core and takes ownership of the bus. It copies 256 bytes from CPU page `{P,8'h00}` into the PPU OAM data port, then hands the bus back. While idle it is a transparent combinational pass-through of the core's bus signals.

## Interface
Parameters:
- `DMA_REG_ADDR`, 16'h4014, CPU address whose write triggers DMA; write data is the source page P.
- `OAM_DATA_ADDR`, 16'h2004, destination address written once per byte.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu_addr`  in  16  core address.
- `cpu_read`  in  1  core read strobe.
- `cpu_write`  in  1  core write strobe.
- `cpu_wdata`  in  8  core write data.
- `cpu_stall`  out  1  to core `stall`; core holds all state while high.
- `bus_addr`  out  16  shared bus address.
- `bus_read`  out  1  shared bus read strobe.
- `bus_write`  out  1  shared bus write strobe.
- `bus_wdata`  out  8  shared bus write data.
- `bus_rdata`  in  8  shared bus read data, valid combinationally in the cycle `bus_read` is high.
- `dma_active`  out  1  high whenever state != IDLE.
- `dma_done`  out  1  one-cycle pulse in the cycle after the final OAM write.

## Operation
- States:
  - IDLE: no transfer; bus is passed through.
  - HALT: one dead cycle after the trigger; bus idle.
  - ALIGN: optional one dead cycle for parity alignment; bus idle.
  - RD: read one source byte.
  - WR: write that byte to OAM.
- Registers:
  - `page[7:0]`: source page.
  - `idx[7:0]`: byte index.
  - `latch[7:0]`: captured read data.
  - `par`: free-running toggle, flips every clock, reset 0.
- Trigger and alignment:
  - IDLE→HALT on an edge where `cpu_write && cpu_addr==DMA_REG_ADDR`; same edge loads `page<=cpu_wdata` and `idx<=0`.
  - A CPU read of `DMA_REG_ADDR` never triggers.
  - HALT→ALIGN if `par==1` during HALT, else HALT→RD.
  - ALIGN→RD unconditionally.
- Transfer loop:
  - RD: `bus_addr={page,idx}`, `bus_read=1`; `latch<=bus_rdata` at the closing edge; RD→WR.
  - WR: `bus_addr=OAM_DATA_ADDR`, `bus_write=1`, `bus_wdata=latch`.
  - At the closing edge of WR: if `idx==8'hFF` go to IDLE and set `dma_done` for the next cycle; else `idx<=idx+1` and go to RD.
  - `idx` is 8-bit; no carry into `page`.
- Bus mux:
  - In IDLE: `bus_addr/read/write/wdata` = `cpu_addr/read/write/wdata`, combinationally.
  - In HALT and ALIGN: `bus_read=bus_write=0`, `bus_addr=cpu_addr`, `bus_wdata=0`.
- Stall and status: `cpu_stall = dma_active`.
- Retrigger: a trigger is impossible while active because the core is stalled; any `DMA_REG_ADDR` write seen while not IDLE is ignored.
- Address coverage: source page may be any value, including `$20`–`$40` register space; no special casing.

## Timing
- Reset (async assert, sync-safe release): state=IDLE, `page=idx=latch=0`, `par=0`, `cpu_stall=0`, `dma_active=0`, `dma_done=0`. Bus outputs immediately become pass-through.
- Reset mid-transfer aborts with no further bus cycles; OAM keeps the bytes already written.
- Trigger write occupies cycle T0 and completes normally on the bus (pass-through).
- `cpu_stall` rises in T1, the cycle after T0.
- Stall length:
  - 513 cycles if `par==0` in HALT (1 + 512).
  - 514 cycles if `par==1` in HALT (1 + 1 + 512).
- The core resumes in the cycle `dma_done` is high; `dma_active==0` in that cycle.
- The first RD is at T2 (even) or T3 (odd). The k-th OAM write is 2k+1 cycles after the first RD (k from 0).
- Back-to-back: a trigger in the `dma_done` cycle is accepted (state is IDLE).

## Test plan
- Even parity: trigger with `cpu_wdata=8'h02` when the T1 `par` value is 0 → stall high for exactly 513 cycles. Bus reads `$0200..$02FF` ascending, each followed by a write to `$2004`. `dma_done` pulses once.
- Odd parity: same trigger shifted one cycle → stall exactly 514 cycles, one idle ALIGN cycle before the first read of `$0200`.
- Data: preload `mem[$0300+i]=i^8'hA5`, trigger page `8'h03` → 256 writes to `$2004` with data `8'hA5, 8'hA4, ..., 8'h5A` in order; no other bus writes during DMA.
- Reset abort: assert `rst=0` while `idx==100` in WR → `cpu_stall`, `dma_active` and `bus_write` go low immediately. After release, the bus mirrors the CPU and no further `$2004` writes occur.
- Non-triggers: CPU read of `$4014`, write to `$4015`, write to `$4014` during an active DMA → no new transfer, no change to `page`, stall count unaffected.
- Pass-through and back-to-back: in IDLE, random CPU traffic appears unchanged on the bus the same cycle. A trigger issued in the `dma_done` cycle starts a second full 513/514-cycle transfer.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA sequencer: stalls the 6502 core, copies one CPU page to the PPU OAM
// data port and otherwise passes the core's bus straight through.
//
// state | meaning
// IDLE  | no transfer, core owns the bus
// HALT  | dead cycle after the trigger write
// ALIGN | extra dead cycle when par is odd in HALT
// RD    | read source byte {page,idx}
// WR    | write latched byte to the OAM data port
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_stall,
  output logic [15:0] bus_addr,
  output logic        bus_read,
  output logic        bus_write,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        dma_active,
  output logic        dma_done
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, RD, WR} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] latch;
  logic       par;
  logic       trig;
  logic       last_byte;

  assign trig      = cpu_write && (cpu_addr == DMA_REG_ADDR);
  assign last_byte = (idx == 8'hFF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      page     <= '0;
      idx      <= '0;
      latch    <= '0;
      par      <= 1'b0;
      dma_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      par      <= ~par;
      dma_done <= (state == WR) && last_byte;
      if (state == IDLE && trig) begin
        page <= cpu_wdata;
        idx  <= '0;
      end
      if (state == RD) latch <= bus_rdata;
      // idx wraps within the page; the source never crosses into page+1
      if (state == WR && !last_byte) idx <= idx + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    bus_addr  = cpu_addr;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    bus_wdata = 8'h00;
    case (state)
      IDLE: begin
        bus_read  = cpu_read;
        bus_write = cpu_write;
        bus_wdata = cpu_wdata;
        if (trig) state_nxt = HALT;
      end
      HALT:  state_nxt = par ? ALIGN : RD;
      ALIGN: state_nxt = RD;
      RD: begin
        bus_addr  = {page, idx};
        bus_read  = 1'b1;
        state_nxt = WR;
      end
      WR: begin
        bus_addr  = OAM_DATA_ADDR;
        bus_write = 1'b1;
        bus_wdata = latch;
        state_nxt = last_byte ? IDLE : RD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dma_active = (state != IDLE);
  assign cpu_stall  = dma_active;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: pass-through, non-triggers, even/odd transfers,
// OAM data order, back-to-back trigger and reset abort.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_addr;
  logic        cpu_read;
  logic        cpu_write;
  logic [7:0]  cpu_wdata;
  logic        cpu_stall;
  logic [15:0] bus_addr;
  logic        bus_read;
  logic        bus_write;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        dma_active;
  logic        dma_done;

  logic [7:0]  mem [0:65535];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          oam_wr = 0;
  int          oam_base;

  oam_dma_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .bus_addr   (bus_addr),
    .bus_read   (bus_read),
    .bus_write  (bus_write),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .dma_active (dma_active),
    .dma_done   (dma_done)
  );

  always #5 clk = ~clk;

  assign bus_rdata = bus_read ? mem[bus_addr] : 8'h00;

  // parity model: par equals the number of clock edges since reset release, mod 2
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst && bus_write && bus_addr == 16'h2004) oam_wr <= oam_wr + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
    cpu_read  = r;
    cpu_write = w;
    cpu_addr  = a;
    cpu_wdata = d;
  endtask

  task automatic passthru(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk); #1;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            16'($urandom_range(0, 16'h0FFF)), 8'($urandom_range(0, 255)));
      @(negedge clk);
      chk($sformatf("pass_%0d", i),
          32'({cpu_stall, dma_active, bus_read, bus_write, bus_addr, bus_wdata}),
          32'({2'b00, cpu_read, cpu_write, cpu_addr, cpu_wdata}));
    end
  endtask

  // Starts the transfer at T0 (or treats the current done cycle as T0 when already=1)
  // and checks every cycle through the dma_done cycle.
  task automatic run_dma(input logic [7:0] pg, input bit noise, input bit chain,
                         input logic [7:0] npg, input bit already, input bit want_odd,
                         input int abort_n);
    bit          odd;
    int          len;
    int          first;
    int          stall_cnt;
    int          j;
    int          k;
    int          base;
    logic        exp_stall;
    logic        exp_done;
    logic        exp_rd;
    logic        exp_wr;
    logic [15:0] exp_addr;
    stall_cnt = 0;
    if (already) begin
      odd = (((cyc + 1) % 2) == 1);
    end else begin
      odd = want_odd;
      @(posedge clk); #1;
      if (((cyc + 1) % 2) != int'(want_odd)) begin
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        @(posedge clk); #1;
      end
      drive(1'b0, 1'b1, 16'h4014, pg);
      @(negedge clk);
      chk("t0_pass", 32'({cpu_stall, dma_active, bus_write, bus_addr, bus_wdata}),
          32'({3'b001, 16'h4014, pg}));
    end
    base  = oam_wr;
    len   = odd ? 514 : 513;
    first = odd ? 3 : 2;
    for (int n = 1; n <= len + 1; n++) begin
      @(posedge clk); #1;
      if (n == len + 1) begin
        if (chain) drive(1'b0, 1'b1, 16'h4014, npg);
        else       drive(1'b0, 1'b0, 16'h0000, 8'h00);
      end else if (noise) begin
        drive(1'b0, 1'b1, 16'h4014, 8'hEE);
      end else begin
        drive(1'b1, 1'b0, 16'h1234, 8'h00);
      end
      @(negedge clk);
      exp_stall = (n <= len);
      exp_done  = (n == len + 1);
      exp_rd    = 1'b0;
      exp_wr    = 1'b0;
      exp_addr  = cpu_addr;
      if (n > len) begin
        exp_rd = cpu_read;
        exp_wr = cpu_write;
      end else if (n >= first) begin
        j = n - first;
        k = j / 2;
        if (j % 2 == 0) begin
          exp_rd   = 1'b1;
          exp_addr = {pg, 8'(k)};
        end else begin
          exp_wr   = 1'b1;
          exp_addr = 16'h2004;
          chk($sformatf("oam_data_%0d", k), 32'(bus_wdata), 32'(mem[{pg, 8'(k)}]));
        end
      end else begin
        chk($sformatf("dead_wdata_%0d", n), 32'(bus_wdata), 32'h0);
      end
      chk($sformatf("cycle_%0d", n),
          32'({cpu_stall, dma_active, dma_done, bus_read, bus_write, bus_addr}),
          32'({exp_stall, exp_stall, exp_done, exp_rd, exp_wr, exp_addr}));
      if (cpu_stall) stall_cnt++;
      if (n == abort_n) begin
        #2 rst = 1'b0;
        #1;
        chk("abort", 32'({cpu_stall, dma_active, dma_done, bus_write, bus_read, bus_addr}),
            32'({4'b0000, 1'b1, 16'h1234}));
        return;
      end
    end
    chk("stall_len", 32'(stall_cnt), 32'(odd ? 514 : 513));
    chk("oam_writes", 32'(oam_wr - base), 32'd256);
  endtask

  initial begin
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
    for (int a = 0; a < 65536; a++) mem[16'(a)] = 8'(a * 7 + 3);
    for (int i = 0; i < 256; i++) mem[16'(16'h0300 + i)] = 8'(i) ^ 8'hA5;

    repeat (3) @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 16'h1234, 8'h5A);
    @(negedge clk);
    chk("rst_status", 32'({cpu_stall, dma_active, dma_done}), 32'h0);
    chk("rst_pass", 32'({bus_read, bus_write, bus_addr, bus_wdata}), 32'({2'b01, 16'h1234, 8'h5A}));

    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
    rst = 1'b1;
    passthru(16);

    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'h4014, 8'h00);
    @(negedge clk);
    chk("rd4014_pass", 32'({bus_read, bus_write, bus_addr}), 32'({2'b10, 16'h4014}));
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 16'h4015, 8'h77);
    @(negedge clk);
    chk("rd4014_nostall", 32'({cpu_stall, dma_active}), 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge clk);
    chk("wr4015_nostall", 32'({cpu_stall, dma_active}), 32'h0);

    run_dma(8'h02, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    run_dma(8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0);
    run_dma(8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 0);
    run_dma(8'h02, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    run_dma(8'h05, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 203);

    @(posedge clk); #1;
    rst = 1'b1;
    oam_base = oam_wr;
    passthru(20);
    chk("no_oam_after_abort", 32'(oam_wr - oam_base), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
